// File: rtl/stopwatch_bcd.sv
// stopwatch_bcd
//
// Four-digit BCD stopwatch, 00.00 to 99.99 s at 10 ms resolution, feeding a
// four-digit seven-segment display driver.
//
// Two raw push-buttons are synchronized, debounced and turned into one-cycle
// press pulses. A small run/stop state machine advances the count. A
// prescaler generates the 10 ms count ticks.
//
// Parameters
//   TICK_DIV  : clk cycles per 10 ms count tick
//   DB_CYCLES : consecutive stable synchronized cycles needed to accept a
//               button level change
//
// Ports
//   clk      in   system clock, rising edge
//   reset    in   asynchronous, active-high, clears every register
//   btn_ss   in   raw start/stop button, active-high, asynchronous to clk
//   btn_clr  in   raw clear button, active-high, asynchronous to clk
//   disp_num out  [3:0] hundredths, [7:4] tenths, [11:8] seconds ones,
//                 [15:12] seconds tens (one BCD digit per nibble)
//   dp_out   out  active-low decimal points, constant 4'b1011
//   running  out  high while the count is running
//   overflow out  high once the count saturated at 99.99, sticky until clear

module stopwatch_bcd #(
   parameter int TICK_DIV  = 500000,
   parameter int DB_CYCLES = 1000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        btn_ss,
   input  logic        btn_clr,
   output logic [15:0] disp_num,
   output logic [3:0]  dp_out,
   output logic        running,
   output logic        overflow
);

   // Widths are guarded so a divider or debounce length of 1 still gets a
   // one-bit counter instead of a zero-width vector.
   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int DW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

   localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
   localparam logic [DW-1:0] DB_MAX  = DW'(DB_CYCLES - 1);

   // ---------------------------------------------------------------------
   // Button front end
   // Index 0 is start/stop and index 1 is clear. Both paths are identical:
   // a 2-flop synchronizer, then a debouncer, then a registered rising-edge
   // pulse.
   // ---------------------------------------------------------------------
   logic [1:0]    raw;
   logic [1:0]    sync1;
   logic [1:0]    sync2;
   logic [1:0]    lvl;
   logic [1:0]    lvl_d;
   logic [1:0]    press;
   logic [DW-1:0] dbc [2];

   assign raw = {btn_clr, btn_ss};

   for (genvar g = 0; g < 2; g++) begin : g_btn
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            sync1[g] <= 1'b0;
            sync2[g] <= 1'b0;
            lvl[g]   <= 1'b0;
            lvl_d[g] <= 1'b0;
            press[g] <= 1'b0;
            dbc[g]   <= '0;
         end else begin
            sync1[g] <= raw[g];
            sync2[g] <= sync1[g];
            // Any return to the accepted level restarts the stability
            // count, so a glitch shorter than DB_CYCLES is dropped.
            if (sync2[g] == lvl[g]) begin
               dbc[g] <= '0;
            end else if (dbc[g] == DB_MAX) begin
               lvl[g] <= sync2[g];
               dbc[g] <= '0;
            end else begin
               dbc[g] <= dbc[g] + DW'(1);
            end
            lvl_d[g] <= lvl[g];
            // The pulse is asserted in the cycle after lvl rises. A release
            // does not produce a pulse.
            press[g] <= lvl[g] & ~lvl_d[g];
         end
      end
   end

   logic ss_pulse;
   logic clr_pulse;

   assign ss_pulse  = press[0];
   assign clr_pulse = press[1];

   // ---------------------------------------------------------------------
   // Run/stop state machine and count datapath
   // ---------------------------------------------------------------------
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_STOP = 2'd2
   } state_t;

   state_t        state;
   state_t        state_n;
   logic [PW-1:0] pre;
   logic [PW-1:0] pre_n;
   logic [15:0]   digits_n;
   logic          ovf_n;
   logic          tick;

   // BCD increment with ripple carry: each digit at 9 wraps to 0 and passes
   // the carry upward. Saturation at 99.99 is handled by the caller, so this
   // function never sees 9999.
   function automatic logic [15:0] bcd_inc(input logic [15:0] d);
      logic [15:0] r;
      logic        carry;
      r     = d;
      carry = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (carry) begin
            if (d[i*4 +: 4] == 4'd9) begin
               r[i*4 +: 4] = 4'd0;
            end else begin
               r[i*4 +: 4] = d[i*4 +: 4] + 4'd1;
               carry       = 1'b0;
            end
         end
      end
      return r;
   endfunction

   always_comb begin
      state_n  = state;
      pre_n    = pre;
      digits_n = disp_num;
      ovf_n    = overflow;
      tick     = (state == S_RUN) && (pre == PRE_MAX);

      if (clr_pulse) begin
         // Clear has priority over start/stop, and any start/stop pulse in
         // the same cycle is discarded.
         state_n  = S_IDLE;
         pre_n    = '0;
         digits_n = '0;
         ovf_n    = 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (ss_pulse) begin
                  state_n = S_RUN;
               end
            end
            S_RUN: begin
               if (tick) begin
                  pre_n = '0;
                  if (disp_num == 16'h9999) begin
                     // The count saturates here and never wraps to 00.00.
                     ovf_n   = 1'b1;
                     state_n = S_STOP;
                  end else begin
                     digits_n = bcd_inc(disp_num);
                  end
               end else begin
                  pre_n = pre + PW'(1);
               end
               // A stop that coincides with a tick keeps that tick's
               // increment.
               if (ss_pulse) begin
                  state_n = S_STOP;
               end
            end
            S_STOP: begin
               // The prescaler is held while stopped, so a resume continues
               // the partial 10 ms period.
               if (ss_pulse && !overflow) begin
                  state_n = S_RUN;
               end
            end
            default: begin
               state_n = S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= S_IDLE;
         pre      <= '0;
         disp_num <= '0;
         overflow <= 1'b0;
         running  <= 1'b0;
      end else begin
         state    <= state_n;
         pre      <= pre_n;
         disp_num <= digits_n;
         overflow <= ovf_n;
         // Registered from the next-state value, so running changes on the
         // same edge as the state register.
         running  <= (state_n == S_RUN);
      end
   end

   // The decimal point sits after the seconds-ones digit (active-low).
   assign dp_out = 4'b1011;

endmodule

// File: tb/tb_stopwatch_bcd.sv
module tb_stopwatch_bcd;

  localparam int TD = 4;
  localparam int DB = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        btn_ss = 1'b0;
  logic        btn_clr = 1'b0;
  logic [15:0] disp_num;
  logic [3:0]  dp_out;
  logic        running;
  logic        overflow;

  int total = 0;
  int bad = 0;

  // Reference model state: count in plain hundredths, state as small int
  // (0 idle, 1 run, 2 stop), cycle number of each clock edge.
  int n = 0;
  int m_cnt = 0;
  int m_st = 0;
  int m_pre = 0;
  int m_ovf = 0;
  int ss_run = 0;
  int clr_run = 0;
  int ss_q[$];
  int clr_q[$];

  stopwatch_bcd #(.TICK_DIV(TD), .DB_CYCLES(DB)) dut (
    .clk(clk),
    .reset(reset),
    .btn_ss(btn_ss),
    .btn_clr(btn_clr),
    .disp_num(disp_num),
    .dp_out(dp_out),
    .running(running),
    .overflow(overflow)
  );

  // clock/reset block
  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // A level held high for DB consecutive samples is a press. Its effect
  // reaches the state machine 4 edges after the DB-th sample, which is
  // DB+3 edges after the first sample.
  task automatic model_edge();
    bit p_ss;
    bit p_clr;
    if (reset) begin
      m_cnt = 0; m_st = 0; m_pre = 0; m_ovf = 0;
      ss_run = 0; clr_run = 0;
      ss_q.delete(); clr_q.delete();
      return;
    end
    p_ss = 1'b0;
    p_clr = 1'b0;
    if (ss_q.size() > 0 && ss_q[0] == n) begin p_ss = 1'b1; void'(ss_q.pop_front()); end
    if (clr_q.size() > 0 && clr_q[0] == n) begin p_clr = 1'b1; void'(clr_q.pop_front()); end
    ss_run  = btn_ss  ? ss_run + 1  : 0;
    clr_run = btn_clr ? clr_run + 1 : 0;
    if (ss_run == DB)  ss_q.push_back(n + 4);
    if (clr_run == DB) clr_q.push_back(n + 4);

    if (p_clr) begin
      m_st = 0; m_cnt = 0; m_pre = 0; m_ovf = 0;
    end else if (m_st == 1) begin
      if (m_pre == TD - 1) begin
        m_pre = 0;
        if (m_cnt == 9999) begin m_ovf = 1; m_st = 2; end
        else m_cnt++;
      end else begin
        m_pre++;
      end
      if (p_ss) m_st = 2;
    end else if (p_ss && m_ovf == 0) begin
      m_st = 1;
    end
  endtask

  // driver task: one clock cycle with the given button levels, then
  // compare every output against the model 1 time unit after the edge.
  task automatic cyc(input logic ss, input logic clr);
    btn_ss = ss;
    btn_clr = clr;
    @(posedge clk);
    n++;
    model_edge();
    #1;
    chk("disp", disp_num, to_bcd(m_cnt));
    chk("running", {15'b0, running}, {15'b0, (m_st == 1)});
    chk("overflow", {15'b0, overflow}, 16'(m_ovf));
    chk("dp", {12'b0, dp_out}, 16'h000b);
  endtask

  initial begin
    logic [15:0] prev_disp;
    bit seen_1000;
    int mode;
    int len;
    int gap;

    // reset, then quiet for 100 cycles
    reset = 1'b1;
    repeat (3) cyc(1'b0, 1'b0);
    reset = 1'b0;
    repeat (100) cyc(1'b0, 1'b0);
    chk("idle_disp", disp_num, 16'h0000);
    chk("idle_run", {15'b0, running}, 16'h0000);

    // a 2-cycle glitch is rejected
    repeat (2) cyc(1'b1, 1'b0);
    repeat (10) cyc(1'b0, 1'b0);
    chk("glitch_run", {15'b0, running}, 16'h0000);

    // held press: RUN 6 edges after the first sample; counting checkpoints
    for (int i = 0; i <= 54; i++) begin
      cyc(i < 10, 1'b0);
      if (i <= 9) chk("ss_latency", {15'b0, running}, {15'b0, (i >= 6)});
      if (i == 45) chk("pre_0010", disp_num, 16'h0009);
      if (i == 46) chk("wrap_0010", disp_num, 16'h0010);
      if (i == 53) chk("cnt_0011", disp_num, 16'h0011);
      if (i == 54) chk("cnt_0012", disp_num, 16'h0012);
    end

    // run up to 99.99, checking the 09.99 -> 10.00 ripple on the way
    seen_1000 = 1'b0;
    for (int i = 0; i < 45000 && m_cnt != 9999; i++) begin
      prev_disp = disp_num;
      cyc(1'b0, 1'b0);
      if (m_cnt == 1000 && !seen_1000) begin
        seen_1000 = 1'b1;
        chk("pre_1000", prev_disp, 16'h0999);
        chk("wrap_1000", disp_num, 16'h1000);
      end
    end
    repeat (8) cyc(1'b0, 1'b0);
    chk("sat_disp", disp_num, 16'h9999);
    chk("sat_ovf", {15'b0, overflow}, 16'h0001);
    chk("sat_run", {15'b0, running}, 16'h0000);

    // start/stop is ignored after overflow
    repeat (5) cyc(1'b1, 1'b0);
    repeat (10) cyc(1'b0, 1'b0);
    chk("ovf_ignore_run", {15'b0, running}, 16'h0000);
    chk("ovf_ignore_disp", disp_num, 16'h9999);

    // clear returns to IDLE
    repeat (5) cyc(1'b0, 1'b1);
    repeat (10) cyc(1'b0, 1'b0);
    chk("clr_disp", disp_num, 16'h0000);
    chk("clr_ovf", {15'b0, overflow}, 16'h0000);
    chk("clr_run", {15'b0, running}, 16'h0000);

    // stop at 00.05 with a partial period, wait, resume
    for (int i = 0; i <= 88; i++) begin
      cyc((i < 4) || (i >= 22 && i < 26) || (i >= 80 && i < 84), 1'b0);
      if (i == 28) chk("stop_run", {15'b0, running}, 16'h0000);
      if (i == 28) chk("stop_disp", disp_num, 16'h0005);
      if (i == 78) chk("held_disp", disp_num, 16'h0005);
      if (i == 86) chk("resume_run", {15'b0, running}, 16'h0001);
      if (i == 87) chk("resume_hold", disp_num, 16'h0005);
      if (i == 88) chk("resume_tick", disp_num, 16'h0006);
    end

    // both buttons together while running: clear wins
    for (int i = 0; i <= 15; i++) begin
      cyc(i < 5, i < 5);
      if (i == 5) chk("both_before", {15'b0, running}, 16'h0001);
      if (i == 6) chk("both_run", {15'b0, running}, 16'h0000);
      if (i == 6) chk("both_disp", disp_num, 16'h0000);
    end

    // reset mid-count with the button held through deassertion
    for (int i = 0; i <= 30; i++) cyc(i < 4, 1'b0);
    reset = 1'b1;
    repeat (3) cyc(1'b1, 1'b0);
    chk("rst_disp", disp_num, 16'h0000);
    chk("rst_run", {15'b0, running}, 16'h0000);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 1'b0);
      chk("rst_press", {15'b0, running}, {15'b0, (i >= 6)});
    end
    repeat (10) cyc(1'b0, 1'b0);

    // randomized presses and glitches, checked every cycle by the model
    for (int e = 0; e < 60; e++) begin
      mode = $urandom_range(0, 9);
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : $urandom_range(3, 8);
      gap = $urandom_range(6, 40);
      for (int i = 0; i < len; i++) cyc(mode <= 6 || mode == 9, mode >= 7);
      for (int i = 0; i < gap; i++) cyc(1'b0, 1'b0);
    end

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
